drum_voice_scheduler: RTL and testbench
=======================================

// Module: drum_voice_scheduler
// PURPOSE
//  Time-multiplexes one shared sample-memory read port among the four drum voices (snare, kick, hat, clap).
//  Sits between the step datapath (1-cycle trigger pulses) and the mixer.
//  On every audio sample strobe it walks voices 0..3, fetches the next sample of each active voice and
//  commits all four outputs together, so the mixer always sees one coherent frame.
// PARAMETERS
//  ADDR_W  16  shared memory address width
//  DATA_W  8   sample width (unsigned)
//  RD_LAT  2   memory read latency in clk cycles, >=1; mem_rdata valid RD_LAT cycles after mem_rd
// PORTS
//  clk          in   1       system clock (CLOCK_50)
//  reset        in   1       synchronous, active-low reset
//  play         in   1       sequencer playing; low = silence all voices
//  sample_tick  in   1       1-cycle audio-rate strobe
//  go           in   4       1-cycle trigger per voice; bit i = voice i
//  mem_rd       out  1       1-cycle read request
//  mem_addr     out  ADDR_W  read address, valid with mem_rd
//  mem_rdata    in   DATA_W  read data
//  out0..out3   out  DATA_W  committed sample per voice
//  busy         out  4       voice i currently active
//  frame_done   out  1       1-cycle pulse, same cycle outputs update
//  overrun      out  1       sticky: sample_tick arrived while a frame was in progress
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): all outputs 0. FSM to IDLE. Active, pending and offset cleared.
//  - Per voice: active, pending, offset[ADDR_W-1:0].
//  - go[i] sets pending[i] in any FSM state. Pending is consumed only at frame start (IDLE->SLOT):
//    active=1, offset=0, pending=0.
//  - FSM:
//    IDLE --sample_tick--> SLOT(v=0).
//    SLOT: if active[v]: ISSUE, else skip to the next voice in 1 cycle; staged[v]=0.
//    ISSUE: mem_rd=1, mem_addr=VOICE_BASE[v]+offset; -> WAIT.
//    WAIT: RD_LAT-1 cycles -> CAPTURE.
//    CAPTURE: staged[v]=mem_rdata; offset++; if offset==VOICE_LEN[v]-1 then active[v]=0.
//    After v=3 -> COMMIT: out0..3<=staged, frame_done=1 -> IDLE.
//  - Latency: worst-case frame = 1 + 4*(RD_LAT+2) + 1 cycles (18 at RD_LAT=2). All-idle frame = 6 cycles.
//  - Last sample of a voice is output for its final frame; the following frame outputs 0.
//  - sample_tick when not IDLE: tick dropped, overrun<=1. Cleared only by reset.
//  - sample_tick and go[i] in the same cycle in IDLE: trigger takes effect in that frame.
//  - play==0: synchronously clears active, pending and staged; outputs 0; FSM to IDLE; an in-flight read is
//    discarded; go ignored. frame_done is not pulsed.
//  - Offset arithmetic is ADDR_W-bit; VOICE_BASE+VOICE_LEN must not exceed 2^ADDR_W (package-time check).
// CONFIGURATION
//  DRUM_SCHED_RETRIG_EN
//   defined:   go[i] on an active voice restarts it at offset 0 at the next frame start.
//   undefined: go[i] while active[i]==1 is ignored (pending not set); only an idle voice can be triggered.
// STRUCTURE
//  - Package drum_sched_pkg:
//    - NUM_VOICES=4
//    - VOICE_BASE = {16'h0000, 16'h1000, 16'h2000, 16'h3000}
//    - VOICE_LEN = {16'd4000, 16'd3000, 16'd1500, 16'd2500}
//    - FSM state enum {IDLE, SLOT, ISSUE, WAIT, CAPTURE, COMMIT}
//  - One sub-module, drum_voice_ctx: per-voice active/pending/offset slice with trigger, advance and
//    end-of-sample compare. Instantiated 4x.
//  - Top keeps FSM, voice index, RD_LAT counter, staging and output registers.
// TESTING
//  - Reset: hold reset=0 2 cycles -> outputs, busy, mem_rd, overrun, frame_done all 0.
//  - Single trigger: play=1, go=4'b0010, then sample_tick -> mem_rd with mem_addr=16'h1000.
//    out1 = model byte at 0x1000 on frame_done; out0/2/3 = 0; next tick reads 0x1001.
//  - End of sample: run voice 2 for 1500 ticks -> last read addr 0x25DB, busy[2] falls at that CAPTURE.
//    Next frame out2=0.
//  - Overrun: sample_tick 5 cycles after a tick with all voices active (RD_LAT=2) -> overrun=1.
//    Frame completes normally, extra tick ignored.
//  - Retrigger: voice 0 at offset 100, go[0] -> with DRUM_SCHED_RETRIG_EN next read 0x0000;
//    without, next read 0x0065.
//  - play drop mid-frame: play=0 during WAIT -> outputs 0, busy=0, no frame_done.
//    play=1 plus tick -> all-idle 6-cycle frame.

Source files
------------

// File: rtl/drum_sched_pkg.sv
// Shared constants, voice memory map and FSM state type for the drum voice scheduler.
// The voice map must fit inside the shared address space; sched_layout_ok() checks this at elaboration.
package drum_sched_pkg;

    localparam int NUM_VOICES = 4;

    localparam logic [15:0] VOICE_BASE [NUM_VOICES] = '{16'h0000, 16'h1000, 16'h2000, 16'h3000};
    localparam logic [15:0] VOICE_LEN  [NUM_VOICES] = '{16'd4000, 16'd3000, 16'd1500, 16'd2500};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SLOT    = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4,
        COMMIT  = 3'd5
    } sched_state_e;

    function automatic bit sched_layout_ok(input int addr_w);
        for (int i = 0; i < NUM_VOICES; i++) begin
            if ((longint'(VOICE_BASE[i]) + longint'(VOICE_LEN[i])) > (longint'(1) << addr_w))
                return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/drum_voice_scheduler_if.sv
// Shared sample-memory read port: the scheduler is the master, the sample memory the slave.
interface drum_voice_scheduler_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_rd, output mem_addr, input mem_rdata);
    modport slave  (input mem_rd, input mem_addr, output mem_rdata);
endinterface

// File: rtl/drum_voice_ctx.sv
// Per-voice playback context: active/pending flags and sample offset with end-of-sample detection.
// DRUM_SCHED_RETRIG_EN: when defined, a trigger on an active voice restarts it at the next frame.
module drum_voice_ctx #(
    parameter int ADDR_W = 16,
    parameter int LEN    = 4000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_play,
    input  logic              i_go,
    input  logic              i_start,
    input  logic              i_advance,
    output logic              o_active,
    output logic [ADDR_W-1:0] o_offset
);
    logic              r_active;
    logic              r_pending;
    logic [ADDR_W-1:0] r_offset;
    logic              w_trig;

`ifdef DRUM_SCHED_RETRIG_EN
    assign w_trig = i_go;
`else
    assign w_trig = i_go && !r_active;
`endif

    always_ff @(posedge clk) begin
        if (!reset || !i_play) begin
            r_active  <= 1'b0;
            r_pending <= 1'b0;
            r_offset  <= '0;
        end else if (i_start && (r_pending || w_trig)) begin
            // a trigger coincident with frame start is consumed in that same frame
            r_active  <= 1'b1;
            r_pending <= 1'b0;
            r_offset  <= '0;
        end else begin
            if (w_trig)
                r_pending <= 1'b1;
            if (i_advance) begin
                r_offset <= r_offset + ADDR_W'(1);
                if (r_offset == ADDR_W'(LEN - 1))
                    r_active <= 1'b0;
            end
        end
    end

    assign o_active = r_active;
    assign o_offset = r_offset;
endmodule

// File: rtl/drum_voice_scheduler.sv
// Walks the four drum voices once per sample tick over one shared memory port and commits a coherent frame.
// Retrigger behaviour of active voices is selected by DRUM_SCHED_RETRIG_EN (see drum_voice_ctx).
module drum_voice_scheduler
    import drum_sched_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_play,
    input  logic                      i_sample_tick,
    input  logic [NUM_VOICES-1:0]     i_go,
    drum_voice_scheduler_if.master    mem,
    output logic [DATA_W-1:0]         o_out0,
    output logic [DATA_W-1:0]         o_out1,
    output logic [DATA_W-1:0]         o_out2,
    output logic [DATA_W-1:0]         o_out3,
    output logic [NUM_VOICES-1:0]     o_busy,
    output logic                      o_frame_done,
    output logic                      o_overrun
);
    localparam int CNT_W    = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam int WAIT_CYC = (RD_LAT > 1) ? RD_LAT - 2 : 0;

    if (!sched_layout_ok(ADDR_W)) begin : g_layout_check
        $error("drum_voice_scheduler: voice map exceeds ADDR_W address space");
    end

    sched_state_e      r_state;
    logic [1:0]        r_voice;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [DATA_W-1:0] r_staged [NUM_VOICES];
    logic [DATA_W-1:0] r_out    [NUM_VOICES];
    logic              r_frame_done;
    logic              r_overrun;

    logic [NUM_VOICES-1:0] w_active;
    logic [ADDR_W-1:0]     w_offset [NUM_VOICES];
    logic                  w_frame_start;
    logic                  w_capture;
    logic                  w_last_voice;

    assign w_frame_start = i_play && (r_state == IDLE) && i_sample_tick;
    assign w_capture     = i_play && (r_state == CAPTURE);
    assign w_last_voice  = (r_voice == 2'(NUM_VOICES - 1));

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        drum_voice_ctx #(
            .ADDR_W (ADDR_W),
            .LEN    (int'(VOICE_LEN[gi]))
        ) u_ctx (
            .clk       (clk),
            .reset     (reset),
            .i_play    (i_play),
            .i_go      (i_go[gi]),
            .i_start   (w_frame_start),
            .i_advance (w_capture && (r_voice == 2'(gi))),
            .o_active  (w_active[gi]),
            .o_offset  (w_offset[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset || !i_play) begin
            // play low aborts any in-flight read and silences the outputs without a frame pulse
            r_state      <= IDLE;
            r_voice      <= '0;
            r_wait_cnt   <= '0;
            r_frame_done <= 1'b0;
            if (!reset)
                r_overrun <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_staged[i] <= '0;
                r_out[i]    <= '0;
            end
        end else begin
            r_frame_done <= 1'b0;
            if (i_sample_tick && (r_state != IDLE))
                r_overrun <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (i_sample_tick) begin
                        r_state <= SLOT;
                        r_voice <= '0;
                    end
                end
                SLOT: begin
                    r_staged[r_voice] <= '0;
                    if (w_active[r_voice])
                        r_state <= ISSUE;
                    else if (w_last_voice)
                        r_state <= COMMIT;
                    else
                        r_voice <= r_voice + 2'd1;
                end
                ISSUE: begin
                    r_wait_cnt <= CNT_W'(WAIT_CYC);
                    r_state    <= (RD_LAT == 1) ? CAPTURE : WAIT;
                end
                WAIT: begin
                    if (r_wait_cnt == '0)
                        r_state <= CAPTURE;
                    else
                        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                end
                CAPTURE: begin
                    r_staged[r_voice] <= mem.mem_rdata;
                    if (w_last_voice) begin
                        r_state <= COMMIT;
                    end else begin
                        r_voice <= r_voice + 2'd1;
                        r_state <= SLOT;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_VOICES; i++)
                        r_out[i] <= r_staged[i];
                    r_frame_done <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem.mem_rd   = i_play && (r_state == ISSUE);
    assign mem.mem_addr = (r_state == ISSUE) ? (ADDR_W'(VOICE_BASE[r_voice]) + w_offset[r_voice]) : '0;

    assign o_out0       = r_out[0];
    assign o_out1       = r_out[1];
    assign o_out2       = r_out[2];
    assign o_out3       = r_out[3];
    assign o_busy       = w_active;
    assign o_frame_done = r_frame_done;
    assign o_overrun    = r_overrun;
endmodule

// File: tb/tb_drum_voice_scheduler.sv
// Self-checking bench: frame-level voice model plus a per-cycle compare process and directed scenarios.
module tb_drum_voice_scheduler;
    localparam int RD_LAT = 2;
`ifdef DRUM_SCHED_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif
    localparam logic [15:0] BASE [4] = '{16'h0000, 16'h1000, 16'h2000, 16'h3000};
    localparam int          LEN  [4] = '{4000, 3000, 1500, 2500};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       play = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] go = 4'b0;
    logic [7:0] out0, out1, out2, out3;
    logic [3:0] busy;
    logic       frame_done, overrun;

    drum_voice_scheduler_if #(.ADDR_W(16), .DATA_W(8)) mem_if ();

    drum_voice_scheduler #(.ADDR_W(16), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_play        (play),
        .i_sample_tick (tick),
        .i_go          (go),
        .mem           (mem_if),
        .o_out0        (out0),
        .o_out1        (out1),
        .o_out2        (out2),
        .o_out3        (out3),
        .o_busy        (busy),
        .o_frame_done  (frame_done),
        .o_overrun     (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // sample memory: data appears RD_LAT cycles after the request, garbage otherwise
    logic [7:0] pipe [RD_LAT];
    always @(posedge clk) begin
        pipe[0] <= mem_if.mem_rd ? mem_byte(mem_if.mem_addr) : 8'hEE;
        for (int k = 1; k < RD_LAT; k++)
            pipe[k] <= pipe[k-1];
    end
    assign mem_if.mem_rdata = pipe[RD_LAT-1];

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          m_en = 1'b0;
    bit          m_active [4];
    bit          m_pending [4];
    int          m_off [4];
    logic [7:0]  m_out [4];
    logic [7:0]  m_shown [4];
    logic [15:0] exp_addr [$];
    int          m_frames = 0;
    int          m_len = 0;
    int          m_tick_cyc = 0;
    logic [15:0] last_addr = 16'h0;
    logic [15:0] v0_addr = 16'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (m_en) begin
            if (mem_if.mem_rd) begin
                last_addr = mem_if.mem_addr;
                if (mem_if.mem_addr < 16'h1000)
                    v0_addr = mem_if.mem_addr;
                check("read_expected", 32'(exp_addr.size() > 0), 32'd1);
                if (exp_addr.size() > 0)
                    check("read_addr", mem_if.mem_addr, exp_addr.pop_front());
            end
            if (frame_done) begin
                check("frame_expected", 32'(m_frames > 0), 32'd1);
                if (m_frames > 0) begin
                    m_frames--;
                    check("frame_len", cyc - m_tick_cyc, m_len);
                    check("reads_left", exp_addr.size(), 0);
                    check("busy", busy, {m_active[3], m_active[2], m_active[1], m_active[0]});
                    for (int v = 0; v < 4; v++)
                        m_shown[v] = m_out[v];
                end
            end
            check("outputs", {out3, out2, out1, out0}, {m_shown[3], m_shown[2], m_shown[1], m_shown[0]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_go(input logic [3:0] g);
        for (int v = 0; v < 4; v++)
            if (g[v] && (RETRIG || !m_active[v]))
                m_pending[v] = 1'b1;
    endtask

    task automatic model_frame(input logic [3:0] g);
        int nact;
        logic [15:0] a;
        nact = 0;
        model_go(g);
        for (int v = 0; v < 4; v++) begin
            if (m_pending[v]) begin
                m_active[v]  = 1'b1;
                m_off[v]     = 0;
                m_pending[v] = 1'b0;
            end
        end
        for (int v = 0; v < 4; v++) begin
            if (m_active[v]) begin
                a = BASE[v] + 16'(m_off[v]);
                exp_addr.push_back(a);
                m_out[v] = mem_byte(a);
                m_off[v]++;
                if (m_off[v] == LEN[v])
                    m_active[v] = 1'b0;
                nact++;
            end else begin
                m_out[v] = 8'h00;
            end
        end
        m_len      = 6 + nact * (RD_LAT + 1);
        m_tick_cyc = cyc;
        m_frames++;
    endtask

    task automatic model_abort();
        exp_addr.delete();
        m_frames = 0;
        for (int v = 0; v < 4; v++) begin
            m_active[v]  = 1'b0;
            m_pending[v] = 1'b0;
            m_out[v]     = 8'h00;
            m_shown[v]   = 8'h00;
        end
    endtask

    task automatic do_go(input logic [3:0] g);
        go = g;
        model_go(g);
        step();
        go = 4'b0;
    endtask

    task automatic do_tick(input logic [3:0] g);
        tick = 1'b1;
        go   = g;
        model_frame(g);
        step();
        tick = 1'b0;
        go   = 4'b0;
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 60 && m_frames != 0; i++)
            step();
        check("frame_timeout", m_frames, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int v = 0; v < 4; v++) begin
            m_active[v] = 1'b0; m_pending[v] = 1'b0; m_off[v] = 0;
            m_out[v] = 8'h00; m_shown[v] = 8'h00;
        end
        step();
        step();
        @(negedge clk);
        check("rst_outputs", {out3, out2, out1, out0}, 32'h0);
        check("rst_busy", busy, 32'h0);
        check("rst_mem_rd", mem_if.mem_rd, 32'h0);
        check("rst_overrun", overrun, 32'h0);
        check("rst_frame_done", frame_done, 32'h0);
        step();
        reset = 1'b1;
        play  = 1'b1;
        m_en  = 1'b1;

        // single trigger on voice 1
        do_go(4'b0010);
        do_tick(4'b0000);
        wait_frame();
        check("single_out1", out1, 8'h4A);
        check("single_others", {out3, out2, out0}, 32'h0);
        check("single_addr", last_addr, 16'h1000);
        do_tick(4'b0000);
        wait_frame();
        check("second_addr", last_addr, 16'h1001);

        // go coincident with tick, then play voice 2 to its end
        do_tick(4'b0100);
        wait_frame();
        check("same_cycle_go_addr", last_addr, 16'h2000);
        repeat (1499) begin
            do_tick(4'b0000);
            wait_frame();
        end
        check("eos_last_addr", last_addr, 16'h25DB);
        check("eos_busy", busy, 4'b0010);
        do_tick(4'b0000);
        wait_frame();
        check("eos_out2_zero", out2, 8'h00);
        check("eos_model_len", m_len, 9);

        // overrun: extra tick five cycles into a full frame
        do_go(4'b1101);
        do_tick(4'b0000);
        check("all_active_len", m_len, 18);
        repeat (4) step();
        check("overrun_before", overrun, 1'b0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        wait_frame();
        check("overrun_set", overrun, 1'b1);
        repeat (25) step();
        check("overrun_sticky", overrun, 1'b1);

        // retrigger voice 0 once it has read address 100
        repeat (100) begin
            do_tick(4'b0000);
            wait_frame();
        end
        check("v0_at_100", v0_addr, 16'h0064);
        do_go(4'b0001);
        do_tick(4'b0000);
        wait_frame();
        check("retrig_addr", v0_addr, RETRIG ? 16'h0000 : 16'h0065);

        // play drop while waiting on voice 0's read
        do_tick(4'b0000);
        step();
        step();
        play = 1'b0;
        step();
        model_abort();
        @(negedge clk);
        check("drop_outputs", {out3, out2, out1, out0}, 32'h0);
        check("drop_busy", busy, 32'h0);
        step();
        repeat (25) step();
        play = 1'b1;
        step();
        do_tick(4'b0000);
        check("idle_frame_len", m_len, 6);
        wait_frame();
        check("idle_frame_out", {out3, out2, out1, out0}, 32'h0);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
